// File: rtl/imem_sync_if.sv
// Fetch bus between the fetch stage and imem_sync.
//   req_valid/req_ready/req_addr : request channel (byte address, 32 bits)
//   rsp_valid/rsp_ready          : response channel handshake
//   rsp_instr                    : fetched word, zero whenever any rsp_err bit is set
//   rsp_err                      : [0] misaligned, [1] out of range, [2] parity
// master = requester/consumer, slave = memory.
interface imem_sync_if #(
  parameter int unsigned DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_instr;
  logic [2:0]        rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_instr, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_instr, rsp_err
  );
endinterface

// File: rtl/imem_sync.sv
// Synchronous instruction memory for the fusa_cpu fetch stage.
// Registered read (latency 1) behind a valid/ready handshake with response
// backpressure. Every word carries an even-parity bit; each response reports
// misalignment, out-of-range and parity faults. With BOOT_LOAD=1 the memory
// starts in LOAD and is written through the load port until load_done;
// with BOOT_LOAD=0 it runs a fixed built-in program.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   bus          : fetch request/response bus (imem_sync_if.slave)
//   load_en      : boot-load write strobe (honoured in LOAD only)
//   load_addr    : word index of the boot-load write
//   load_data    : word to write; parity is generated internally
//   load_done    : one-cycle pulse, LOAD -> RUN
//   inj_par_err  : flips the stored parity bit of the accompanying load write
//   fault_flag   : sticky parity-fault flag, cleared only by rst
//   fault_cnt    : saturating parity-fault counter
module imem_sync #(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BOOT_LOAD = 0,
  parameter int unsigned FCNT_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  imem_sync_if.slave               bus,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [DATA_W-1:0]        load_data,
  input  logic                     load_done,
  input  logic                     inj_par_err,
  output logic                     fault_flag,
  output logic [FCNT_W-1:0]        fault_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [0:0] ST_LOAD  = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [0:0] ST_RESET = (BOOT_LOAD != 0) ? ST_LOAD : ST_RUN;

  logic [0:0]        state_q, state_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_instr_q, rsp_instr_d;
  logic [2:0]        rsp_err_q, rsp_err_d;
  logic              fault_flag_q, fault_flag_d;
  logic [FCNT_W-1:0] fault_cnt_q, fault_cnt_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              par_q [DEPTH];

  logic              req_ready;
  logic              accept;
  logic [AW-1:0]     idx;
  logic              mis_err;
  logic              oor_err;
  logic              par_err;
  logic [2:0]        err;
  logic [DATA_W-1:0] rom_w;
  logic [DATA_W-1:0] rd_word;
  logic              rd_par;

  // Built-in program; parity for these words is derived from the data, so
  // the image is always parity-correct.
  function automatic logic [DATA_W-1:0] rom_word(input logic [AW-1:0] i);
    logic [DATA_W-1:0] w;
    case (32'(i))
      32'd0:   w = DATA_W'(32'h2001_0005);
      32'd1:   w = DATA_W'(32'h2002_000a);
      32'd2:   w = DATA_W'(32'h0022_1820);
      32'd3:   w = DATA_W'(32'hac03_0000);
      32'd4:   w = DATA_W'(32'h1000_ffff);
      default: w = '0;
    endcase
    return w;
  endfunction

  assign req_ready = (state_q == ST_RUN) & (~rsp_valid_q | bus.rsp_ready);
  assign accept    = bus.req_valid & req_ready;

  assign idx     = bus.req_addr[AW+1:2];
  assign mis_err = |bus.req_addr[1:0];
  // Addresses past the array are flagged, never aliased onto a valid index.
  assign oor_err = |bus.req_addr[31:AW+2];
  assign rom_w   = rom_word(idx);

  always_comb begin
    if (BOOT_LOAD != 0) begin
      rd_word = mem_q[idx];
      rd_par  = par_q[idx];
    end else begin
      rd_word = rom_w;
      rd_par  = ^rom_w;
    end
  end

  // Parity is only meaningful for a legal address.
  assign par_err = ~mis_err & ~oor_err & (^rd_word ^ rd_par);
  assign err     = {par_err, oor_err, mis_err};

  always_comb begin
    state_d = state_q;
    if (state_q == ST_LOAD && load_done) begin
      state_d = ST_RUN;
    end
  end

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_instr_d  = rsp_instr_q;
    rsp_err_d    = rsp_err_q;
    fault_flag_d = fault_flag_q;
    fault_cnt_d  = fault_cnt_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_instr_d = (|err) ? '0 : rd_word;
      rsp_err_d   = err;
      if (par_err) begin
        fault_flag_d = 1'b1;
        if (fault_cnt_q != '1) begin
          fault_cnt_d = fault_cnt_q + FCNT_W'(1);
        end
      end
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RESET;
      rsp_valid_q  <= 1'b0;
      rsp_instr_q  <= '0;
      rsp_err_q    <= '0;
      fault_flag_q <= 1'b0;
      fault_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_instr_q  <= rsp_instr_d;
      rsp_err_q    <= rsp_err_d;
      fault_flag_q <= fault_flag_d;
      fault_cnt_q  <= fault_cnt_d;
    end
  end

  // Storage survives rst; a write in the load_done cycle still lands.
  always_ff @(posedge clk) begin
    if (state_q == ST_LOAD && load_en) begin
      mem_q[load_addr] <= load_data;
      par_q[load_addr] <= (^load_data) ^ inj_par_err;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_instr = rsp_instr_q;
  assign bus.rsp_err   = rsp_err_q;
  assign fault_flag    = fault_flag_q;
  assign fault_cnt     = fault_cnt_q;

endmodule

// File: tb/tb_imem_sync.sv
module tb_imem_sync;

  localparam int unsigned DEPTH  = 256;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned FCNT_W = 8;
  localparam int unsigned AW     = $clog2(DEPTH);

  logic clk;
  logic rst0, rst1;

  // u0: built-in program, u1: boot-load
  logic              l0_en, l0_done, l0_inj;
  logic [AW-1:0]     l0_addr;
  logic [DATA_W-1:0] l0_data;
  logic              ff0;
  logic [FCNT_W-1:0] fc0;

  logic              l1_en, l1_done, l1_inj;
  logic [AW-1:0]     l1_addr;
  logic [DATA_W-1:0] l1_data;
  logic              ff1;
  logic [FCNT_W-1:0] fc1;

  int unsigned n_vec;
  int unsigned n_err;

  imem_sync_if #(.DATA_W(DATA_W)) bus0 ();
  imem_sync_if #(.DATA_W(DATA_W)) bus1 ();

  imem_sync #(.DEPTH(DEPTH), .DATA_W(DATA_W), .BOOT_LOAD(0), .FCNT_W(FCNT_W)) u0 (
    .clk(clk), .rst(rst0), .bus(bus0),
    .load_en(l0_en), .load_addr(l0_addr), .load_data(l0_data),
    .load_done(l0_done), .inj_par_err(l0_inj),
    .fault_flag(ff0), .fault_cnt(fc0)
  );

  imem_sync #(.DEPTH(DEPTH), .DATA_W(DATA_W), .BOOT_LOAD(1), .FCNT_W(FCNT_W)) u1 (
    .clk(clk), .rst(rst1), .bus(bus1),
    .load_en(l1_en), .load_addr(l1_addr), .load_data(l1_data),
    .load_done(l1_done), .inj_par_err(l1_inj),
    .fault_flag(ff1), .fault_cnt(fc1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] addrs [5];
  logic [31:0] words [5];

  initial begin
    n_vec = 0;
    n_err = 0;
    addrs[0] = 32'h0;  words[0] = 32'h2001_0005;
    addrs[1] = 32'h4;  words[1] = 32'h2002_000a;
    addrs[2] = 32'h8;  words[2] = 32'h0022_1820;
    addrs[3] = 32'hC;  words[3] = 32'hac03_0000;
    addrs[4] = 32'h10; words[4] = 32'h1000_ffff;

    rst0 = 1'b1; rst1 = 1'b1;
    bus0.req_valid = 1'b0; bus0.req_addr = '0; bus0.rsp_ready = 1'b1;
    bus1.req_valid = 1'b0; bus1.req_addr = '0; bus1.rsp_ready = 1'b1;
    l0_en = 1'b0; l0_done = 1'b0; l0_inj = 1'b0; l0_addr = '0; l0_data = '0;
    l1_en = 1'b0; l1_done = 1'b0; l1_inj = 1'b0; l1_addr = '0; l1_data = '0;

    // Reset values
    #12;
    chk("rst_rsp_valid", 64'(bus0.rsp_valid), 64'd0);
    chk("rst_rsp_instr", 64'(bus0.rsp_instr), 64'd0);
    chk("rst_rsp_err",   64'(bus0.rsp_err),   64'd0);
    chk("rst_fault",     64'({ff0, fc0}),     64'd0);
    chk("rst_u0_ready",  64'(bus0.req_ready), 64'd1);
    chk("rst_u1_ready",  64'(bus1.req_ready), 64'd0);
    rst0 = 1'b0; rst1 = 1'b0;
    step();

    // 1: back-to-back fetches of the built-in program
    bus0.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus0.req_addr = addrs[i];
      #1;
      chk("b2b_ready", 64'(bus0.req_ready), 64'd1);
      step();
      chk("b2b_valid", 64'(bus0.rsp_valid), 64'd1);
      chk("b2b_instr", 64'(bus0.rsp_instr), 64'(words[i]));
      chk("b2b_err",   64'(bus0.rsp_err),   64'd0);
    end
    bus0.req_valid = 1'b0;
    step();
    chk("b2b_drain", 64'(bus0.rsp_valid), 64'd0);

    // 2: backpressure on a fetch of 0x4
    bus0.req_valid = 1'b1; bus0.req_addr = 32'h4;
    step();
    bus0.rsp_ready = 1'b0;
    bus0.req_addr  = 32'h8;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_valid", 64'(bus0.rsp_valid), 64'd1);
      chk("bp_instr", 64'(bus0.rsp_instr), 64'h2002_000a);
      chk("bp_ready", 64'(bus0.req_ready), 64'd0);
      step();
    end
    bus0.rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(bus0.req_ready), 64'd1);
    step();
    chk("bp_next_instr", 64'(bus0.rsp_instr), 64'h0022_1820);
    chk("bp_next_valid", 64'(bus0.rsp_valid), 64'd1);
    bus0.req_valid = 1'b0;
    step();
    chk("bp_drain", 64'(bus0.rsp_valid), 64'd0);

    // 3: address faults
    bus0.req_valid = 1'b1;
    bus0.req_addr = 32'h6;
    step();
    chk("mis_err",   64'(bus0.rsp_err),   64'b001);
    chk("mis_instr", 64'(bus0.rsp_instr), 64'd0);
    bus0.req_addr = 32'h400;
    step();
    chk("oor_err",   64'(bus0.rsp_err),   64'b010);
    chk("oor_instr", 64'(bus0.rsp_instr), 64'd0);
    bus0.req_addr = 32'h402;
    step();
    chk("both_err",   64'(bus0.rsp_err),   64'b011);
    chk("both_instr", 64'(bus0.rsp_instr), 64'd0);
    bus0.req_addr = 32'h8000_0000;
    step();
    chk("msb_oor_err", 64'(bus0.rsp_err), 64'b010);
    bus0.req_valid = 1'b0;
    step();
    chk("addr_fault_cnt", 64'({ff0, fc0}), 64'd0);

    // 6: load port ignored in RUN
    l0_en = 1'b1; l0_addr = '0; l0_data = 32'h1234_5678; l0_done = 1'b1;
    step();
    l0_en = 1'b0; l0_done = 1'b0;
    bus0.req_valid = 1'b1; bus0.req_addr = 32'h0;
    step();
    chk("run_load_ignored", 64'(bus0.rsp_instr), 64'h2001_0005);
    chk("run_load_err",     64'(bus0.rsp_err),   64'd0);

    // 5: async reset with a response pending
    bus0.rsp_ready = 1'b0;
    bus0.req_valid = 1'b0;
    step();
    chk("pre_rst_valid", 64'(bus0.rsp_valid), 64'd1);
    #2 rst0 = 1'b1;
    #1;
    chk("async_rst_valid", 64'(bus0.rsp_valid), 64'd0);
    chk("async_rst_instr", 64'(bus0.rsp_instr), 64'd0);
    #1 rst0 = 1'b0;
    bus0.rsp_ready = 1'b1;
    bus0.req_valid = 1'b1; bus0.req_addr = 32'h0;
    step();
    chk("post_rst_instr", 64'(bus0.rsp_instr), 64'h2001_0005);
    bus0.req_valid = 1'b0;

    // 4: boot-load with injected parity fault
    bus1.req_valid = 1'b1; bus1.req_addr = 32'h1C;
    #1;
    chk("load_ready", 64'(bus1.req_ready), 64'd0);
    l1_en = 1'b1; l1_addr = AW'(7); l1_data = 32'hDEAD_BEEF; l1_inj = 1'b1;
    step();
    chk("load_no_rsp", 64'(bus1.rsp_valid), 64'd0);
    // write together with load_done still lands
    l1_inj = 1'b0; l1_addr = AW'(8); l1_data = 32'h0000_0003; l1_done = 1'b1;
    step();
    l1_en = 1'b0; l1_done = 1'b0;
    #1;
    chk("run_ready", 64'(bus1.req_ready), 64'd1);
    step();
    chk("par_err",   64'(bus1.rsp_err),   64'b100);
    chk("par_instr", 64'(bus1.rsp_instr), 64'd0);
    chk("par_flag",  64'(ff1),            64'd1);
    chk("par_cnt1",  64'(fc1),            64'd1);
    bus1.req_addr = 32'h20;
    step();
    chk("done_write_instr", 64'(bus1.rsp_instr), 64'h0000_0003);
    chk("done_write_err",   64'(bus1.rsp_err),   64'd0);
    chk("done_write_cnt",   64'(fc1),            64'd1);
    bus1.req_addr = 32'h1C;
    repeat (253) step();
    chk("cnt_254", 64'(fc1), 64'd254);
    repeat (47) step();
    bus1.req_valid = 1'b0;
    step();
    chk("cnt_sat", 64'(fc1), 64'd255);
    chk("flag_sticky", 64'(ff1), 64'd1);

    // reset keeps loaded memory, clears fault state
    #2 rst1 = 1'b1;
    #1;
    chk("u1_rst_cnt", 64'({ff1, fc1}), 64'd0);
    #1 rst1 = 1'b0;
    bus1.req_valid = 1'b1;
    #1;
    chk("u1_rst_load_state", 64'(bus1.req_ready), 64'd0);
    l1_done = 1'b1;
    step();
    l1_done = 1'b0;
    step();
    chk("u1_mem_kept_err", 64'(bus1.rsp_err), 64'b100);
    chk("u1_mem_kept_cnt", 64'(fc1),          64'd1);
    bus1.req_valid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
